// File: rtl/unidade_controle_jogo.sv
// Moore control unit for one round of the memory game.
// Sequences the datapath: address counter, jogada register, memory, comparator.
// Waits for each player move, registers it and compares it with the stored value.
// Ends the round in acertou, errou or timeout.
module unidade_controle_jogo #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       chaves_ativas,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registrador,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  // State codes double as the 7-segment debug value.
  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    PREPARACAO    = 4'b0001,
    ESPERA_JOGADA = 4'b0010,
    REGISTRA      = 4'b0100,
    COMPARACAO    = 4'b0101,
    PROXIMO       = 4'b0110,
    FIM_ACERTOU   = 4'b1010,
    FIM_ERROU     = 4'b1110,
    FIM_TIMEOUT   = 4'b1101
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          chaves_q, chaves_d;
  logic          jogada;

  // A move is a rising edge of chaves_ativas; the edge register tracks the
  // keys every cycle, so keys already held when espera_jogada is entered
  // do not count until they are released and pressed again.
  assign chaves_d = chaves_ativas;
  assign jogada   = chaves_ativas & ~chaves_q;

  // State, timer and edge registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      timer_q  <= '0;
      chaves_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      chaves_q <= chaves_d;
    end
  end

  // Next-state and timer logic; a move beats timer expiry in espera_jogada.
  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        timer_d  = '0;
        estado_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        timer_d = timer_q + TIMER_ONE;
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (timer_q == TIMER_LAST) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA: begin
        estado_d = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual) begin
          estado_d = FIM_ERROU;
        end else if (fim_contagem) begin
          estado_d = FIM_ACERTOU;
        end else begin
          estado_d = PROXIMO;
        end
      end
      PROXIMO: begin
        timer_d  = '0;
        estado_d = ESPERA_JOGADA;
      end
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    zera_contador    = 1'b0;
    conta_contador   = 1'b0;
    zera_registrador = 1'b0;
    registra         = 1'b0;
    acertou          = 1'b0;
    errou            = 1'b0;
    timeout          = 1'b0;
    case (estado_q)
      PREPARACAO: begin
        zera_contador    = 1'b1;
        zera_registrador = 1'b1;
      end
      REGISTRA:    registra       = 1'b1;
      PROXIMO:     conta_contador = 1'b1;
      FIM_ACERTOU: acertou        = 1'b1;
      FIM_ERROU:   errou          = 1'b1;
      FIM_TIMEOUT: timeout        = 1'b1;
      default: ;
    endcase
    pronto = acertou | errou | timeout;
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for unidade_controle_jogo with a small behavioural datapath
// (address counter, jogada register, 4-entry memory 1,2,4,8, comparator).
module tb_unidade_controle_jogo;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       chaves_ativas, igual, fim_contagem;
  logic       zera_contador, conta_contador, zera_registrador, registra;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  logic [1:0] addr;
  logic [3:0] jog_reg;
  int         n_reg, n_conta;
  int         n_tests, n_fail;
  int         base_reg, base_conta;

  localparam logic [3:0] S_INI = 4'b0000, S_PREP = 4'b0001, S_ESP = 4'b0010,
                         S_REG = 4'b0100, S_CMP = 4'b0101, S_PROX = 4'b0110,
                         S_OK = 4'b1010, S_ERR = 4'b1110, S_TMO = 4'b1101;

  unidade_controle_jogo #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .chaves_ativas(chaves_ativas), .igual(igual), .fim_contagem(fim_contagem),
    .zera_contador(zera_contador), .conta_contador(conta_contador),
    .zera_registrador(zera_registrador), .registra(registra),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] mem_val(input logic [1:0] a);
    case (a)
      2'd0:    mem_val = 4'b0001;
      2'd1:    mem_val = 4'b0010;
      2'd2:    mem_val = 4'b0100;
      default: mem_val = 4'b1000;
    endcase
  endfunction

  assign chaves_ativas = |chaves;
  assign igual         = (jog_reg == mem_val(addr));
  assign fim_contagem  = (addr == 2'd3);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr    <= 2'd0;
      jog_reg <= 4'd0;
      n_reg   <= 0;
      n_conta <= 0;
    end else begin
      if (zera_contador) addr <= 2'd0;
      else if (conta_contador) addr <= addr + 2'd1;
      if (zera_registrador) jog_reg <= 4'd0;
      else if (registra) jog_reg <= chaves;
      if (registra) n_reg <= n_reg + 1;
      if (conta_contador) n_conta <= n_conta + 1;
    end
  end

  wire [7:0] outs = {zera_contador, conta_contador, zera_registrador, registra,
                     pronto, acertou, errou, timeout};

  // Output table per state: {zc, cc, zr, reg, pronto, acertou, errou, timeout}
  function automatic logic [7:0] exp_outs(input logic [3:0] st);
    case (st)
      S_PREP:  exp_outs = 8'b1010_0000;
      S_REG:   exp_outs = 8'b0001_0000;
      S_PROX:  exp_outs = 8'b0100_0000;
      S_OK:    exp_outs = 8'b0000_1100;
      S_ERR:   exp_outs = 8'b0000_1010;
      S_TMO:   exp_outs = 8'b0000_1001;
      default: exp_outs = 8'b0000_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st);
    check({tag, "/estado"}, {28'd0, db_estado}, {28'd0, st});
    check({tag, "/saidas"}, {24'd0, outs}, {24'd0, exp_outs(st)});
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic start_round(input string tag);
    iniciar = 1'b1;
    tick();
    expect_state({tag, "/prep"}, S_PREP);
    iniciar = 1'b0;
    tick();
    expect_state({tag, "/espera"}, S_ESP);
  endtask

  // Key held 2 cycles, then released while the result state is shown.
  task automatic jogar(input string tag, input logic [3:0] key, input logic [3:0] st_res);
    chaves = key;
    tick();
    expect_state({tag, "/registra"}, S_REG);
    tick();
    expect_state({tag, "/comparacao"}, S_CMP);
    chaves = 4'd0;
    tick();
    expect_state({tag, "/resultado"}, st_res);
    if (st_res == S_PROX) begin
      tick();
      expect_state({tag, "/volta_espera"}, S_ESP);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chaves  = 4'd0;
    iniciar = 1'b1;
    reset   = 1'b1;
    #1 reset = 1'b0;

    // Reset with iniciar held high
    tick();
    expect_state("reset", S_INI);
    reset   = 1'b1;
    iniciar = 1'b0;
    tick();
    expect_state("pos_reset", S_INI);

    // Happy path, with an ignored mid-round iniciar
    base_reg   = n_reg;
    base_conta = n_conta;
    start_round("ok");
    jogar("ok_m1", 4'b0001, S_PROX);
    iniciar = 1'b1;
    tick();
    expect_state("ok_iniciar_ignorado", S_ESP);
    iniciar = 1'b0;
    jogar("ok_m2", 4'b0010, S_PROX);
    jogar("ok_m3", 4'b0100, S_PROX);
    jogar("ok_m4", 4'b1000, S_OK);
    check("ok_n_registra", n_reg - base_reg, 4);
    check("ok_n_conta", n_conta - base_conta, 3);
    tick();
    expect_state("ok_hold", S_OK);

    // Wrong second move
    start_round("err");
    base_conta = n_conta;
    jogar("err_m1", 4'b0001, S_PROX);
    jogar("err_m2", 4'b1001, S_ERR);
    check("err_n_conta", n_conta - base_conta, 1);
    check("err_addr", {30'd0, addr}, 1);
    tick();
    expect_state("err_hold", S_ERR);

    // Restart from fim_errou, then timeout with no keys
    start_round("restart");
    for (int i = 1; i <= 7; i++) begin
      tick();
      expect_state("tmo_wait", S_ESP);
    end
    tick();
    expect_state("tmo_fim", S_TMO);
    tick();
    expect_state("tmo_hold", S_TMO);

    // Key edge on the last espera cycle wins over expiry
    start_round("tmo_edge");
    for (int i = 1; i <= 7; i++) tick();
    chaves = 4'b0001;
    tick();
    expect_state("tmo_edge_registra", S_REG);
    tick();
    expect_state("tmo_edge_cmp", S_CMP);
    chaves = 4'd0;
    tick();
    expect_state("tmo_edge_prox", S_PROX);
    tick();
    expect_state("tmo_edge_espera", S_ESP);

    // Asynchronous reset between clock edges
    #1 reset = 1'b0;
    #1;
    expect_state("async_reset", S_INI);
    #1 reset = 1'b1;
    tick();
    expect_state("async_pos", S_INI);

    // Key held through preparacao does not count as a move
    base_reg = n_reg;
    chaves   = 4'b0001;
    iniciar  = 1'b1;
    tick();
    expect_state("held_prep", S_PREP);
    iniciar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state("held_espera", S_ESP);
    end
    chaves = 4'd0;
    tick();
    expect_state("held_solta", S_ESP);
    check("held_sem_registra", n_reg - base_reg, 0);
    chaves = 4'b0001;
    tick();
    expect_state("held_reaperta", S_REG);
    tick();
    expect_state("held_cmp", S_CMP);
    chaves = 4'd0;
    tick();
    expect_state("held_prox", S_PROX);
    check("held_n_registra", n_reg - base_reg, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore control unit that sequences the game datapath (address counter, jogada register, memory, comparator) for one round of the memory game. It starts on iniciar and waits for each player move. It registers the move, checks it against the stored value, then advances, or ends in acertou, errou or timeout. It replaces the ad-hoc control of the experiment 3 circuit and drives the same datapath control pins.

Parameters:
TIMEOUT, 5000, clock cycles allowed in espera_jogada before timeout (≥2); timer width = $clog2(TIMEOUT)+1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start/restart request, level sampled each clock
chaves_ativas  input  1  OR of the 4 chaves bits from the datapath
igual  input  1  comparator result (chaves register == memory)
fim_contagem  input  1  address counter at last position
zera_contador  output  1  synchronous clear of address counter
conta_contador  output  1  counter increment enable
zera_registrador  output  1  clear of jogada register
registra  output  1  load enable of jogada register
pronto  output  1  round finished
acertou  output  1  round finished, all moves correct
errou  output  1  round finished, wrong move
timeout  output  1  round finished, no move in time
db_estado  output  4  current state code for 7-seg debug

Behaviour:
- Reset (reset=0, async): state=inicial, timer=0, edge register=0. Every output is 0 and db_estado=0000.
- All outputs are decoded from the state register only (Moore). An input sampled at edge N changes outputs after edge N.
- Move detection: the edge register samples chaves_ativas every cycle. jogada = chaves_ativas & ~edge_reg.
  - jogada is only acted on in espera_jogada; edges in other states are discarded.
  - Keys held high across entry into espera_jogada do not count as a move; they must go low and high again.
- States (code):
  - inicial (0000): outputs 0. iniciar=1 -> preparacao.
  - preparacao (0001): zera_contador=1, zera_registrador=1, timer cleared. -> espera_jogada unconditionally (1 cycle).
  - espera_jogada (0010): timer increments each cycle.
    - jogada=1 -> registra.
    - Otherwise, timer==TIMEOUT-1 -> fim_timeout.
    - Simultaneous jogada and expiry: jogada wins.
  - registra (0100): registra=1 for 1 cycle. -> comparacao.
  - comparacao (0101): no enables.
    - igual=0 -> fim_errou.
    - igual=1 & fim_contagem=1 -> fim_acertou.
    - igual=1 & fim_contagem=0 -> proximo.
  - proximo (0110): conta_contador=1, timer cleared. -> espera_jogada.
  - fim_acertou (1010): pronto=1, acertou=1.
  - fim_errou (1110): pronto=1, errou=1.
  - fim_timeout (1101): pronto=1, timeout=1.
  - Terminal states: hold until iniciar=1 -> preparacao (new round, flags drop the next cycle).
- iniciar is ignored in every non-terminal state except inicial; a mid-round press does not restart.
- acertou, errou and timeout are mutually exclusive; pronto = OR of the three.
- Unused state codes -> inicial on the next clock.
- reset=0 at any time, including mid-round, forces inicial immediately, without waiting for a clock edge.
- Latency:
  - iniciar to zera_contador: 1 cycle.
  - Move edge to registra: 1 cycle.
  - registra to result state: 2 cycles.

Test Plan:
1. Reset check: reset=0 for 1 cycle then 1 -> db_estado=0000, all outputs 0, even with iniciar=1 held during reset.
2. Happy path (4-entry memory 0001,0010,0100,1000, TIMEOUT=8): pulse iniciar, then apply each correct key for 2 cycles with 1 low cycle between.
   - Each move gives exactly one registra pulse and each proximo one conta_contador pulse.
   - After the 4th move: fim_acertou, pronto=1, acertou=1, db_estado=1010.
3. Wrong move: 2nd key 1001 instead of 0010 -> comparacao then fim_errou, errou=1, pronto=1, db_estado=1110; counter was incremented once only.
4. Timeout: TIMEOUT=8, no keys after iniciar -> fim_timeout exactly 8 cycles after entering espera_jogada, timeout=1, db_estado=1101.
   - Key edge on the 8th cycle -> registra, not timeout.
5. Held key and restart:
   - Keys held 0001 through preparacao -> no registra until released and re-pressed.
   - In fim_errou, pulse iniciar -> preparacao with zera_contador=1, errou drops to 0.
6. Async reset mid-round: reset=0 between clock edges while in espera_jogada -> state 0000 and outputs 0 before the next edge.
